// File: rtl/spi_mem_ctrl.sv
// SPI initiator for the spi_mem responder: serialises opcode, address and write data
// LSB-first on miso, collects read data from mosi, and aborts on a ready/op_done timeout.
module spi_mem_ctrl #(
    parameter int TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       newd,
    input  logic       wr,
    input  logic [7:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       cs,
    output logic       miso,
    input  logic       mosi,
    input  logic       ready,
    input  logic       op_done
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        OPC,
        SHIFT,
        WAIT_RDY,
        RECV,
        WAIT_DONE
    } state_t;

    state_t        state, state_nxt;
    logic          wr_q, wr_nxt;
    logic [15:0]   shreg, shreg_nxt;
    logic [4:0]    bit_cnt, bit_nxt;
    logic [7:0]    cap, cap_nxt;
    logic [2:0]    rcnt, rcnt_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic          cs_nxt, miso_nxt, busy_nxt, done_nxt, err_nxt;
    logic [7:0]    dout_nxt;
    logic          timed_out;

    assign timed_out = (tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            wr_q    <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
            cap     <= '0;
            rcnt    <= '0;
            tcnt    <= '0;
            cs      <= 1'b1;
            miso    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            dout    <= '0;
        end else begin
            state   <= state_nxt;
            wr_q    <= wr_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_nxt;
            cap     <= cap_nxt;
            rcnt    <= rcnt_nxt;
            tcnt    <= tcnt_nxt;
            cs      <= cs_nxt;
            miso    <= miso_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            err     <= err_nxt;
            dout    <= dout_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wr_nxt    = wr_q;
        shreg_nxt = shreg;
        bit_nxt   = bit_cnt;
        cap_nxt   = cap;
        rcnt_nxt  = rcnt;
        tcnt_nxt  = tcnt;
        cs_nxt    = cs;
        miso_nxt  = miso;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        err_nxt   = err;
        dout_nxt  = dout;

        case (state)
            IDLE: begin
                cs_nxt   = 1'b1;
                miso_nxt = 1'b0;
                if (newd) begin
                    wr_nxt    = wr;
                    shreg_nxt = {din, addr};
                    bit_nxt   = '0;
                    cs_nxt    = 1'b0;
                    miso_nxt  = wr;
                    busy_nxt  = 1'b1;
                    err_nxt   = 1'b0;
                    state_nxt = OPC;
                end
            end

            OPC: begin
                miso_nxt  = wr_q;
                state_nxt = SHIFT;
            end

            // Reads stop after the address byte; writes continue through the data byte.
            SHIFT: begin
                if (bit_cnt == (wr_q ? 5'd16 : 5'd8)) begin
                    miso_nxt = 1'b0;
                    tcnt_nxt = '0;
                    if (wr_q) begin
                        cs_nxt    = 1'b1;
                        state_nxt = WAIT_DONE;
                    end else begin
                        state_nxt = WAIT_RDY;
                    end
                end else begin
                    miso_nxt  = shreg[0];
                    shreg_nxt = {1'b0, shreg[15:1]};
                    bit_nxt   = bit_cnt + 5'd1;
                end
            end

            WAIT_RDY: begin
                if (ready) begin
                    cap_nxt   = {mosi, cap[7:1]};
                    cs_nxt    = 1'b1;
                    rcnt_nxt  = '0;
                    state_nxt = RECV;
                end else if (timed_out) begin
                    cs_nxt    = 1'b1;
                    err_nxt   = 1'b1;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    tcnt_nxt = tcnt + TW'(1);
                end
            end

            // Shifting right LSB-first leaves the first captured bit in cap[0].
            RECV: begin
                cap_nxt  = {mosi, cap[7:1]};
                rcnt_nxt = rcnt + 3'd1;
                if (rcnt == 3'd6) begin
                    tcnt_nxt  = '0;
                    state_nxt = WAIT_DONE;
                end
            end

            WAIT_DONE: begin
                if (op_done) begin
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    if (!wr_q) begin
                        dout_nxt = cap;
                    end
                    state_nxt = IDLE;
                end else if (timed_out) begin
                    cs_nxt    = 1'b1;
                    err_nxt   = 1'b1;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    tcnt_nxt = tcnt + TW'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Bench for spi_mem_ctrl: a behavioural spi_mem responder plus a per-cycle timeline
// model of the controller outputs, with literal spot checks of the key transactions.
module tb_spi_mem_ctrl;

    localparam int TIMEOUT = 32;
    localparam int K_NORMAL = 0;
    localparam int K_TIMEOUT = 1;
    localparam int K_ABORT = 2;

    logic       clk;
    logic       rst;
    logic       newd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       busy;
    logic       done;
    logic       err;
    logic       cs;
    logic       miso;
    logic       mosi = 1'b0;
    logic       ready = 1'b0;
    logic       op_done = 1'b0;

    int tests = 0;
    int fails = 0;

    spi_mem_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .newd(newd), .wr(wr), .addr(addr), .din(din),
        .dout(dout), .busy(busy), .done(done), .err(err), .cs(cs), .miso(miso),
        .mosi(mosi), .ready(ready), .op_done(op_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Responder: samples on the falling edge and drives its outputs there too.
    logic [7:0] mem_store [256];
    logic       mem_rst = 1'b1;
    logic       no_ready = 1'b0;
    logic       prev_cs = 1'b1;
    logic [1:0] opc;
    logic [7:0] r_addr;
    logic [7:0] r_data;
    int         pos = -1;

    always @(negedge clk) begin
        logic fin;
        fin = 1'b0;
        if (mem_rst) begin
            pos = -1;
            ready = 1'b0;
            op_done = 1'b0;
            mosi = 1'b0;
        end else if (pos < 0) begin
            if (!cs) begin
                tests++;
                if (prev_cs !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL cs_gap at %0t: prev cs=%b want 1", $time, prev_cs);
                end
                opc[0] = miso;
                pos = 1;
            end
        end else begin
            if (pos == 1) begin
                opc[1] = miso;
                tests++;
                if (opc[1] !== opc[0]) begin
                    fails++;
                    $display("[TB] FAIL opcode_hold at %0t: got %b want %b", $time, opc[1], opc[0]);
                end
            end else if (pos <= 9) begin
                r_addr[pos-2] = miso;
            end else if (opc[0] && pos <= 17) begin
                r_data[pos-10] = miso;
            end
            if (opc[0]) begin
                if (pos == 19) begin
                    op_done = 1'b1;
                    mem_store[r_addr] = r_data;
                end else if (pos == 20) begin
                    op_done = 1'b0;
                    fin = 1'b1;
                end
            end else begin
                if (pos >= 10 && no_ready) begin
                    if (cs) fin = 1'b1;
                end else if (pos >= 12 && pos <= 19) begin
                    ready = 1'b1;
                    mosi = mem_store[r_addr][pos-12];
                end else if (pos == 20) begin
                    ready = 1'b0;
                    mosi = 1'b0;
                    op_done = 1'b1;
                end else if (pos == 21) begin
                    op_done = 1'b0;
                    fin = 1'b1;
                end
            end
            pos = fin ? -1 : pos + 1;
        end
        prev_cs = cs;
    end

    // Output model: one expected record per falling edge, derived from the timing rules.
    typedef struct packed {
        logic       cs;
        logic       miso;
        logic       busy;
        logic       done;
        logic       err;
        logic [7:0] dout;
    } obs_t;

    obs_t       exp_q[$];
    logic [7:0] model_mem [256];
    logic [7:0] hold_dout = 8'h00;
    logic       hold_err = 1'b0;

    function automatic obs_t idle_obs();
        obs_t o;
        o.cs = 1'b1;
        o.miso = 1'b0;
        o.busy = 1'b0;
        o.done = 1'b0;
        o.err = hold_err;
        o.dout = hold_dout;
        return o;
    endfunction

    function automatic int txn_len(input logic w, input int kind);
        if (kind == K_TIMEOUT) return 10 + TIMEOUT;
        return w ? 20 : 21;
    endfunction

    task automatic push_txn(input logic w, input logic [7:0] a, input logic [7:0] d, input int kind);
        obs_t       o;
        int         last;
        logic [7:0] rd;
        last = txn_len(w, kind);
        rd = model_mem[a];
        if (exp_q.size() == 0) exp_q.push_back(idle_obs());
        for (int k = 0; k <= last; k++) begin
            if (w) o.cs = (k >= 18);
            else if (kind == K_TIMEOUT) o.cs = (k >= last);
            else o.cs = (k >= 13);
            if (k < 2) o.miso = w;
            else if (k < 10) o.miso = a[k-2];
            else if (k < 18 && w) o.miso = d[k-10];
            else o.miso = 1'b0;
            o.busy = (k < last);
            o.done = (k == last);
            o.err = (kind == K_TIMEOUT) && (k == last);
            o.dout = (k == last && !w && kind == K_NORMAL) ? rd : hold_dout;
            exp_q.push_back(o);
        end
        hold_err = (kind == K_TIMEOUT);
        if (!w && kind == K_NORMAL) hold_dout = rd;
        if (w && kind != K_ABORT) model_mem[a] = d;
    endtask

    always @(negedge clk) begin
        obs_t got;
        obs_t want;
        got.cs = cs;
        got.miso = miso;
        got.busy = busy;
        got.done = done;
        got.err = err;
        got.dout = dout;
        if (exp_q.size() != 0) want = exp_q.pop_front();
        else want = idle_obs();
        tests++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL cycle at %0t: got cs=%b miso=%b busy=%b done=%b err=%b dout=%h, want cs=%b miso=%b busy=%b done=%b err=%b dout=%h",
                     $time, got.cs, got.miso, got.busy, got.done, got.err, got.dout,
                     want.cs, want.miso, want.busy, want.done, want.err, want.dout);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Called just after a rising edge; the request is accepted on the next one.
    task automatic applyStimulus(input logic w, input logic [7:0] a, input logic [7:0] d, input int kind);
        push_txn(w, a, d, kind);
        newd = 1'b1;
        wr = w;
        addr = a;
        din = d;
        @(posedge clk);
        #2;
        newd = 1'b0;
        wr = 1'($urandom);
        addr = 8'($urandom);
        din = 8'($urandom);
    endtask

    task automatic observe(input int last, input int poke_k, output int done_idx,
                           output logic [7:0] dout_at, output logic err_at, output logic cs_at,
                           output logic [17:0] seq, output int cs_low);
        done_idx = -1;
        dout_at = 8'h00;
        err_at = 1'b0;
        cs_at = 1'b0;
        seq = '0;
        cs_low = 0;
        for (int k = 0; k <= last + 3; k++) begin
            @(negedge clk);
            if (k < 18) seq = {seq[16:0], miso};
            if (!cs) cs_low++;
            if (done && done_idx < 0) begin
                done_idx = k;
                dout_at = dout;
                err_at = err;
                cs_at = cs;
            end
            if (k == poke_k) begin
                newd = 1'b1;
                wr = 1'b0;
                addr = 8'h03;
                din = 8'hFF;
            end else if (k == poke_k + 1) begin
                newd = 1'b0;
            end
        end
        @(posedge clk);
        #2;
    endtask

    int          d_idx;
    logic [7:0]  d_val;
    logic        e_val;
    logic        c_val;
    logic [17:0] m_seq;
    int          c_low;

    task automatic runTxn(input logic w, input logic [7:0] a, input logic [7:0] d, input int kind, input int poke_k);
        applyStimulus(w, a, d, kind);
        observe(txn_len(w, kind), poke_k, d_idx, d_val, e_val, c_val, m_seq, c_low);
    endtask

    initial begin
        rst = 1'b0;
        newd = 1'b0;
        wr = 1'b0;
        addr = 8'h00;
        din = 8'h00;
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = 8'(i);
            mem_store[i] = 8'(i);
        end
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_cs", 32'(cs), 32'd1);
        checkOutput("reset_busy_done_err", 32'({busy, done, err, miso}), 32'd0);
        checkOutput("reset_dout", 32'(dout), 32'd0);
        rst = 1'b1;
        mem_rst = 1'b0;
        @(posedge clk);
        #2;

        runTxn(1'b1, 8'h03, 8'hA5, K_NORMAL, -10);
        checkOutput("wr_miso_seq", 32'(m_seq), 32'h3C0A5);
        checkOutput("wr_cs_low_cycles", 32'(c_low), 32'd18);
        checkOutput("wr_done_cycle", 32'(d_idx), 32'd20);
        checkOutput("wr_err", 32'(e_val), 32'd0);

        runTxn(1'b0, 8'h03, 8'h00, K_NORMAL, -10);
        checkOutput("rd03_dout", 32'(d_val), 32'hA5);
        checkOutput("rd03_done_cycle", 32'(d_idx), 32'd21);
        checkOutput("rd03_err", 32'(e_val), 32'd0);

        runTxn(1'b1, 8'h1F, 8'h5A, K_NORMAL, -10);
        runTxn(1'b0, 8'h1F, 8'h00, K_NORMAL, -10);
        checkOutput("rd1f_dout", 32'(d_val), 32'h5A);

        runTxn(1'b1, 8'h40, 8'h77, K_NORMAL, 6);
        runTxn(1'b0, 8'h40, 8'h00, K_NORMAL, 6);
        checkOutput("busy_ignore_dout", 32'(d_val), 32'h77);

        applyStimulus(1'b1, 8'h22, 8'hC3, K_NORMAL);
        for (int i = 0; i < 40 && exp_q.size() > 1; i++) begin
            @(posedge clk);
            #2;
        end
        applyStimulus(1'b0, 8'h22, 8'h00, K_NORMAL);
        observe(21, -10, d_idx, d_val, e_val, c_val, m_seq, c_low);
        checkOutput("b2b_dout", 32'(d_val), 32'hC3);
        checkOutput("b2b_done_cycle", 32'(d_idx), 32'd21);

        no_ready = 1'b1;
        runTxn(1'b0, 8'h55, 8'h00, K_TIMEOUT, -10);
        no_ready = 1'b0;
        checkOutput("timeout_done_cycle", 32'(d_idx), 32'd42);
        checkOutput("timeout_err", 32'(e_val), 32'd1);
        checkOutput("timeout_cs", 32'(c_val), 32'd1);
        checkOutput("timeout_dout_kept", 32'(d_val), 32'hC3);

        runTxn(1'b0, 8'h1F, 8'h00, K_NORMAL, -10);
        checkOutput("after_timeout_err", 32'(e_val), 32'd0);

        applyStimulus(1'b1, 8'hFF, 8'h00, K_ABORT);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        mem_rst = 1'b1;
        exp_q.delete();
        hold_dout = 8'h00;
        hold_err = 1'b0;
        #1;
        checkOutput("async_rst_cs", 32'(cs), 32'd1);
        checkOutput("async_rst_busy", 32'(busy), 32'd0);
        checkOutput("async_rst_miso", 32'(miso), 32'd0);
        checkOutput("async_rst_dout", 32'(dout), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        mem_rst = 1'b0;
        @(posedge clk);
        #2;
        runTxn(1'b0, 8'hFF, 8'h00, K_NORMAL, -10);
        checkOutput("post_rst_read", 32'(d_val), 32'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
